// File: rtl/booth_r4_mul.sv
// Iterative radix-4 Booth multiplier with per-operand signed/unsigned modes.
// Operands enter on a valid/ready handshake; the product is held until accepted.
module booth_r4_mul #(
  parameter int DATAWIDTH = 32  // even, >= 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     a_signed,
  input  logic                     b_signed,
  input  logic [DATAWIDTH-1:0]     multiplier,
  input  logic [DATAWIDTH-1:0]     multiplicand,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*DATAWIDTH-1:0]   product
);

  // Two guard bits make every mode combination a plain signed Booth multiply.
  localparam int W  = DATAWIDTH + 2;
  localparam int N  = W / 2;
  localparam int HW = W + 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state;
  logic [HW-1:0]   hi;
  logic [W-1:0]    lo;
  logic            prev;
  logic [W-1:0]    b_reg;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    a_ext;
  logic [W-1:0]    b_ext;
  logic [HW-1:0]   b_hw;
  logic [HW-1:0]   b_x2;
  logic [HW-1:0]   pp;
  logic [HW-1:0]   sum;
  logic [HW-1:0]   step_hi;
  logic [W-1:0]    step_lo;

  assign a_ext = {{2{a_signed & multiplier[DATAWIDTH-1]}}, multiplier};
  assign b_ext = {{2{b_signed & multiplicand[DATAWIDTH-1]}}, multiplicand};
  assign b_hw  = {{2{b_reg[W-1]}}, b_reg};
  assign b_x2  = {b_hw[HW-2:0], 1'b0};

  // One Booth digit per cycle: {A[2i+1], A[2i], A[2i-1]} selects 0, +-B, +-2B.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    pp = '0;
    case ({lo[1:0], prev})
      3'b001, 3'b010: pp = b_hw;
      3'b011:         pp = b_x2;
      3'b100:         pp = -b_x2;
      3'b101, 3'b110: pp = -b_hw;
      default:        pp = '0;
    endcase
    sum     = hi + pp;
    step_hi = {{2{sum[HW-1]}}, sum[HW-1:2]};
    step_lo = {sum[1:0], lo[W-1:2]};
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      hi        <= '0;
      lo        <= '0;
      prev      <= 1'b0;
      b_reg     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            hi       <= '0;
            lo       <= a_ext;
            prev     <= 1'b0;
            b_reg    <= b_ext;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          hi   <= step_hi;
          lo   <= step_lo;
          prev <= lo[1];
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // After N shifts the low 2*DATAWIDTH bits of {hi, lo} are the product.
            product   <= {step_hi[DATAWIDTH-3:0], step_lo};
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mul.sv
// Bench for booth_r4_mul: a 32-bit and an 8-bit instance, each checked every
// cycle against an arithmetic model of the handshake timing and the product.
module tb_booth_r4_mul;

  localparam int N_W = 17;
  localparam int N_8 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int     passed = 0;
  int     total  = 0;
  longint cyc    = 0;
  bit     chk_en = 1'b0;

  // 32-bit instance
  logic        rst_w, iv_w, ir_w, as_w, bs_w, ov_w, or_w;
  logic [31:0] a_w, b_w;
  logic [63:0] p_w;
  // 8-bit instance
  logic        rst_8, iv_8, ir_8, as_8, bs_8, ov_8, or_8;
  logic [7:0]  a_8, b_8;
  logic [15:0] p_8;

  booth_r4_mul #(.DATAWIDTH(32)) dut_w (
    .clk(clk), .rst(rst_w), .in_valid(iv_w), .in_ready(ir_w),
    .a_signed(as_w), .b_signed(bs_w), .multiplier(a_w), .multiplicand(b_w),
    .out_valid(ov_w), .out_ready(or_w), .product(p_w)
  );

  booth_r4_mul #(.DATAWIDTH(8)) dut_8 (
    .clk(clk), .rst(rst_8), .in_valid(iv_8), .in_ready(ir_8),
    .a_signed(as_8), .b_signed(bs_8), .multiplier(a_8), .multiplicand(b_8),
    .out_valid(ov_8), .out_ready(or_8), .product(p_8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Exact product of the mode-extended operands, truncated to 2*dw bits.
  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit as, input bit bs, input int dw);
    logic signed [65:0]  ea, eb;
    logic signed [131:0] p;
    logic [63:0]         r;
    for (int i = 0; i < 66; i++) begin
      if (i < dw) begin
        ea[i] = a[i];
        eb[i] = b[i];
      end else begin
        ea[i] = as & a[dw-1];
        eb[i] = bs & b[dw-1];
      end
    end
    p = ea * eb;
    r = p[63:0];
    if (dw < 32) r = r & ((64'd1 << (2 * dw)) - 64'd1);
    return r;
  endfunction

  // Protocol-level model: busy from accept until the handshake that ends DONE.
  bit          m_busy_w = 1'b0, m_busy_8 = 1'b0;
  longint      m_t_w = 0, m_t_8 = 0;
  logic [63:0] m_exp_w = '0, m_exp_8 = '0;
  int          acc_w = 0, acc_8 = 0;
  bit          stream_8 = 1'b0, have_prev_8 = 1'b0;
  longint      prev_t_8 = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst_w) m_busy_w = 1'b0;
    else if (!m_busy_w && iv_w) begin
      m_busy_w = 1'b1;
      m_t_w    = cyc;
      m_exp_w  = model_mul(a_w, b_w, as_w, bs_w, 32);
      acc_w++;
    end else if (m_busy_w && cyc > m_t_w + N_W && or_w) m_busy_w = 1'b0;

    if (rst_8) m_busy_8 = 1'b0;
    else if (!m_busy_8 && iv_8) begin
      m_busy_8 = 1'b1;
      m_t_8    = cyc;
      m_exp_8  = model_mul({24'b0, a_8}, {24'b0, b_8}, as_8, bs_8, 8);
      acc_8++;
      if (stream_8 && have_prev_8) check("period_8", cyc - prev_t_8, 64'd7);
      prev_t_8    = cyc;
      have_prev_8 = stream_8;
    end else if (m_busy_8 && cyc > m_t_8 + N_8 && or_8) m_busy_8 = 1'b0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready_w", ir_w, !m_busy_w);
      check("out_valid_w", ov_w, m_busy_w && cyc >= m_t_w + N_W);
      if (m_busy_w && cyc >= m_t_w + N_W) check("product_w", p_w, m_exp_w);
      check("in_ready_8", ir_8, !m_busy_8);
      check("out_valid_8", ov_8, m_busy_8 && cyc >= m_t_8 + N_8);
      if (m_busy_8 && cyc >= m_t_8 + N_8) check("product_8", {48'b0, p_8}, m_exp_8);
    end
  end

  logic [31:0] corners_w [5] = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
  logic [7:0]  corners_8 [5] = '{8'h00, 8'h01, 8'h80, 8'h7F, 8'hFF};

  function automatic logic [31:0] pick_w();
    if ($urandom_range(2) == 0) return corners_w[$urandom_range(4)];
    return $urandom;
  endfunction

  function automatic logic [7:0] pick_8();
    if ($urandom_range(3) == 0) return corners_8[$urandom_range(4)];
    return 8'($urandom);
  endfunction

  // Single directed transaction on the 32-bit instance with a literal expectation.
  task automatic op_w(input string name, input logic [31:0] a, input logic [31:0] b,
                      input bit as, input bit bs, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    check({name, " ready"}, ir_w, 1'b1);
    a_w = a; b_w = b; as_w = as; bs_w = bs; iv_w = 1'b1; or_w = 1'b1;
    @(negedge clk);
    iv_w = 1'b0;
    lat = 0;
    while (!ov_w && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd17);
    check({name, " product"}, p_w, exp);
  endtask

  initial begin
    logic [63:0] hold;
    int          lat;

    rst_w = 1'b1; iv_w = 1'b0; as_w = 1'b0; bs_w = 1'b0; a_w = '0; b_w = '0; or_w = 1'b0;
    rst_8 = 1'b1; iv_8 = 1'b0; as_8 = 1'b0; bs_8 = 1'b0; a_8 = '0; b_8 = '0; or_8 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", ir_w, 1'b1);
    check("reset out_valid", ov_w, 1'b0);
    check("reset product", p_w, 64'h0);
    rst_w = 1'b0; rst_8 = 1'b0;
    chk_en = 1'b1;

    check("model signed -1*-1", model_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32), 64'h1);
    check("model unsigned max", model_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32), 64'hFFFF_FFFE_0000_0001);
    check("model 8b min*min", model_mul(32'h80, 32'h80, 1, 1, 8), 64'h4000);

    op_w("s*s -1*-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 64'h0000_0000_0000_0001);
    op_w("s*s min*min", 32'h8000_0000, 32'h8000_0000, 1, 1, 64'h4000_0000_0000_0000);
    op_w("u*u max*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 64'hFFFF_FFFE_0000_0001);
    op_w("s*u -2*3", 32'hFFFF_FFFE, 32'h0000_0003, 1, 0, 64'hFFFF_FFFF_FFFF_FFFA);
    op_w("zero", 32'h0, 32'h1234_5678, 1, 1, 64'h0);

    // Backpressure: hold DONE while the producer scribbles on the inputs.
    @(negedge clk);
    a_w = 32'h1234_5678; b_w = 32'h9ABC_DEF0; as_w = 1'b0; bs_w = 1'b1; iv_w = 1'b1; or_w = 1'b0;
    @(negedge clk);
    iv_w = 1'b0;
    lat = 0;
    while (!ov_w && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    hold = p_w;
    check("bp product", hold, model_mul(32'h1234_5678, 32'h9ABC_DEF0, 0, 1, 32));
    for (int i = 0; i < 5; i++) begin
      iv_w = ~iv_w; a_w = $urandom; b_w = $urandom; as_w = ~as_w;
      @(negedge clk);
      check("bp stable", p_w, hold);
      check("bp in_ready low", ir_w, 1'b0);
      check("bp out_valid held", ov_w, 1'b1);
    end
    iv_w = 1'b0; or_w = 1'b1;
    @(negedge clk);
    check("bp handshake out_valid", ov_w, 1'b0);
    check("bp in_ready back", ir_w, 1'b1);
    @(negedge clk);
    check("bp single handshake", ov_w, 1'b0);

    // Reset in the middle of CALC discards the operation.
    a_w = 32'hDEAD_BEEF; b_w = 32'hCAFE_F00D; as_w = 1'b1; bs_w = 1'b1; iv_w = 1'b1;
    @(negedge clk);
    iv_w = 1'b0;
    repeat (5) @(negedge clk);
    rst_w = 1'b1;
    @(negedge clk);
    rst_w = 1'b0;
    check("midrst in_ready", ir_w, 1'b1);
    check("midrst out_valid", ov_w, 1'b0);
    check("midrst product", p_w, 64'h0);
    op_w("after reset 7*6", 32'd7, 32'd6, 1, 1, 64'd42);

    // Random traffic on the 32-bit instance with random backpressure.
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      a_w = pick_w(); b_w = pick_w();
      as_w = 1'($urandom); bs_w = 1'($urandom);
      iv_w = ($urandom_range(3) != 0);
      or_w = ($urandom_range(2) != 0);
    end
    @(negedge clk);
    iv_w = 1'b0; or_w = 1'b1;
    repeat (25) @(negedge clk);
    check("random_w progress", 64'(acc_w >= 150), 64'd1);

    // Back-to-back stream on the 8-bit instance; every accept should be 7 cycles apart.
    stream_8 = 1'b1;
    for (int c = 0; c < 14000; c++) begin
      @(negedge clk);
      a_8 = pick_8(); b_8 = pick_8();
      as_8 = 1'($urandom); bs_8 = 1'($urandom);
      iv_8 = 1'b1; or_8 = 1'b1;
    end
    @(negedge clk);
    iv_8 = 1'b0;
    stream_8 = 1'b0;
    repeat (10) @(negedge clk);
    check("stream_8 progress", 64'(acc_8 >= 1990), 64'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
